// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light safety monitor: light codes,
// fault codes, direction indices and the monitor FSM encoding.
package traffic_pkg;

  localparam int NUM_DIR = 4;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_ILLEGAL      = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_BAD_SEQ      = 3'd3;
  localparam logic [2:0] FC_TIMEOUT      = 3'd4;
  localparam logic [2:0] FC_STARVE       = 3'd5;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd6;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_W = 2'd2;
  localparam logic [1:0] DIR_S = 2'd3;

  typedef enum logic {
    MON = 1'b0,
    FLT = 1'b1
  } mon_state_e;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

  function automatic logic [1:0] lowest_dir(input logic [3:0] v);
    logic [1:0] d;
    casez (v)
      4'b???1: d = DIR_N;
      4'b??10: d = DIR_E;
      4'b?100: d = DIR_W;
      default: d = DIR_S;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/light_phase_checker.sv
// Per-direction phase tracker: remembers the previous light code and its
// dwell time, and flags encoding, sequence and dwell violations on the input.
module light_phase_checker
  import traffic_pkg::*;
#(
  parameter int MAX_GREEN  = 64,
  parameter int MAX_YELLOW = 16,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 256
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_resync,
  input  logic [2:0] i_light,
  output logic       o_illegal,
  output logic       o_bad_seq,
  output logic       o_timeout,
  output logic       o_starve,
  output logic       o_short_yellow
);

  localparam int CW = $clog2(MAX_RED + 2);
  localparam logic [CW-1:0] DWELL_ONE = CW'(1);
  localparam logic [CW-1:0] DWELL_SAT = CW'(MAX_RED + 1);

  logic [2:0]    r_prev;
  logic [CW-1:0] r_dwell;
  logic          w_hold;
  logic          w_legal_step;
  logic [CW-1:0] w_next_dwell;

  // Dwell checks use the count this cycle would produce, hence "would exceed".
  always_comb begin
    w_hold       = (i_light == r_prev);
    w_legal_step = ((r_prev == LIGHT_RED)    && (i_light == LIGHT_GREEN))  ||
                   ((r_prev == LIGHT_GREEN)  && (i_light == LIGHT_YELLOW)) ||
                   ((r_prev == LIGHT_YELLOW) && (i_light == LIGHT_RED));
    if (!w_hold) begin
      w_next_dwell = DWELL_ONE;
    end else if (r_dwell == DWELL_SAT) begin
      w_next_dwell = r_dwell;
    end else begin
      w_next_dwell = r_dwell + DWELL_ONE;
    end
    o_illegal      = !is_legal(i_light);
    o_bad_seq      = !w_hold && !w_legal_step;
    o_timeout      = ((i_light == LIGHT_GREEN)  && (w_next_dwell > CW'(MAX_GREEN))) ||
                     ((i_light == LIGHT_YELLOW) && (w_next_dwell > CW'(MAX_YELLOW)));
    o_starve       = (i_light == LIGHT_RED) && (w_next_dwell > CW'(MAX_RED));
    o_short_yellow = (r_prev == LIGHT_YELLOW) && (i_light == LIGHT_RED) &&
                     (r_dwell < CW'(MIN_YELLOW));
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_prev  <= LIGHT_RED;
      r_dwell <= DWELL_ONE;
    end else if (i_resync) begin
      r_prev  <= i_light;
      r_dwell <= DWELL_ONE;
    end else if (i_en) begin
      r_prev  <= i_light;
      r_dwell <= w_next_dwell;
    end else begin
      r_prev  <= r_prev;
      r_dwell <= r_dwell;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor between the traffic controller and the lamp drivers: passes
// lights through one register stage and forces flashing red on any violation.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MAX_GREEN  = 64,
  parameter int MAX_YELLOW = 16,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 256,
  parameter int BLINK_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_NORTH,
  input  logic [2:0] light_EAST,
  input  logic [2:0] light_WEST,
  input  logic [2:0] light_SOUTH,
  input  logic       clear_fault,
  output logic [2:0] lamp_NORTH,
  output logic [2:0] lamp_EAST,
  output logic [2:0] lamp_WEST,
  output logic [2:0] lamp_SOUTH,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF);

  logic [2:0]         w_light [NUM_DIR];
  logic [NUM_DIR-1:0] w_illegal, w_bad_seq, w_timeout, w_starve, w_short_yellow;
  logic [NUM_DIR-1:0] w_nonred;
  logic               w_mon, w_exit, w_viol;
  logic [2:0]         w_code;
  logic [1:0]         w_dir;

  mon_state_e         r_state;
  logic [2:0]         r_lamp [NUM_DIR];
  logic               r_fault;
  logic [2:0]         r_code;
  logic [1:0]         r_dir;
  logic [BW-1:0]      r_blink_cnt;
  logic               r_blink_on;

  assign w_light[0] = light_NORTH;
  assign w_light[1] = light_EAST;
  assign w_light[2] = light_WEST;
  assign w_light[3] = light_SOUTH;

  assign w_mon  = (r_state == MON);
  assign w_exit = (r_state == FLT) && clear_fault && (w_nonred == 4'b0000);

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_dir
    light_phase_checker #(
      .MAX_GREEN (MAX_GREEN),
      .MAX_YELLOW(MAX_YELLOW),
      .MIN_YELLOW(MIN_YELLOW),
      .MAX_RED   (MAX_RED)
    ) u_chk (
      .clk           (clk),
      .i_rst_n       (reset),
      .i_en          (w_mon),
      .i_resync      (w_exit),
      .i_light       (w_light[g]),
      .o_illegal     (w_illegal[g]),
      .o_bad_seq     (w_bad_seq[g]),
      .o_timeout     (w_timeout[g]),
      .o_starve      (w_starve[g]),
      .o_short_yellow(w_short_yellow[g])
    );
  end

  // Conflict blames the second-lowest non-red direction: clear the lowest set bit first.
  always_comb begin
    for (int i = 0; i < NUM_DIR; i++) begin
      w_nonred[i] = (w_light[i] != LIGHT_RED);
    end
    if (|w_illegal) begin
      w_code = FC_ILLEGAL;      w_dir = lowest_dir(w_illegal);
    end else if ($countones(w_nonred) > 1) begin
      w_code = FC_CONFLICT;     w_dir = lowest_dir(w_nonred & (w_nonred - 4'd1));
    end else if (|w_bad_seq) begin
      w_code = FC_BAD_SEQ;      w_dir = lowest_dir(w_bad_seq);
    end else if (|w_timeout) begin
      w_code = FC_TIMEOUT;      w_dir = lowest_dir(w_timeout);
    end else if (|w_starve) begin
      w_code = FC_STARVE;       w_dir = lowest_dir(w_starve);
    end else if (|w_short_yellow) begin
      w_code = FC_SHORT_YELLOW; w_dir = lowest_dir(w_short_yellow);
    end else begin
      w_code = FC_NONE;         w_dir = DIR_N;
    end
    w_viol = (w_code != FC_NONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= MON;
      r_fault     <= 1'b0;
      r_code      <= FC_NONE;
      r_dir       <= DIR_N;
      r_blink_cnt <= BLINK_ONE;
      r_blink_on  <= 1'b1;
      for (int i = 0; i < NUM_DIR; i++) r_lamp[i] <= LIGHT_RED;
    end else begin
      case (r_state)
        MON: begin
          if (w_viol) begin
            r_state     <= FLT;
            r_fault     <= 1'b1;
            r_code      <= w_code;
            r_dir       <= w_dir;
            r_blink_cnt <= BLINK_ONE;
            r_blink_on  <= 1'b1;
            for (int i = 0; i < NUM_DIR; i++) r_lamp[i] <= LIGHT_RED;
          end else begin
            for (int i = 0; i < NUM_DIR; i++) r_lamp[i] <= w_light[i];
          end
        end
        FLT: begin
          if (w_exit) begin
            r_state <= MON;
            r_fault <= 1'b0;
            r_code  <= FC_NONE;
            r_dir   <= DIR_N;
            for (int i = 0; i < NUM_DIR; i++) r_lamp[i] <= w_light[i];
          end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= BLINK_ONE;
            r_blink_on  <= !r_blink_on;
            for (int i = 0; i < NUM_DIR; i++) r_lamp[i] <= r_blink_on ? LIGHT_OFF : LIGHT_RED;
          end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
            for (int i = 0; i < NUM_DIR; i++) r_lamp[i] <= r_blink_on ? LIGHT_RED : LIGHT_OFF;
          end
        end
        default: r_state <= MON;
      endcase
    end
  end

  assign lamp_NORTH = r_lamp[0];
  assign lamp_EAST  = r_lamp[1];
  assign lamp_WEST  = r_lamp[2];
  assign lamp_SOUTH = r_lamp[3];
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign fault_dir  = r_dir;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized controller
// traffic, all compared against a behavioural model of the monitor rules.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, OFF = 3'b000;
  localparam int MAX_GREEN = 64, MAX_YELLOW = 16, MIN_YELLOW = 2, MAX_RED = 256, BLINK_HALF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_fault = 1'b0;
  logic [2:0] light [4];
  logic [2:0] lamp_NORTH, lamp_EAST, lamp_WEST, lamp_SOUTH;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;

  int checks = 0;
  int failures = 0;

  logic [2:0] m_prev [4];
  int         m_dwell [4];
  logic [2:0] m_lamp [4];
  bit         m_fault;
  int         m_code, m_dir, m_fcyc;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset),
    .light_NORTH(light[0]), .light_EAST(light[1]), .light_WEST(light[2]), .light_SOUTH(light[3]),
    .clear_fault(clear_fault),
    .lamp_NORTH(lamp_NORTH), .lamp_EAST(lamp_EAST), .lamp_WEST(lamp_WEST), .lamp_SOUTH(lamp_SOUTH),
    .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [2:0] succ(input logic [2:0] p);
    case (p)
      R: return G;
      G: return Y;
      Y: return R;
      default: return OFF;
    endcase
  endfunction

  // Candidates are keyed code*8+dir so the smallest key is the reported fault.
  function automatic void model_step();
    int best, nonred, cdir, nd;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin m_prev[i] = R; m_dwell[i] = 1; m_lamp[i] = R; end
      m_fault = 0; m_code = 0; m_dir = 0; m_fcyc = 0;
      return;
    end
    if (m_fault) begin
      if (clear_fault && light[0] == R && light[1] == R && light[2] == R && light[3] == R) begin
        m_fault = 0; m_code = 0; m_dir = 0;
        for (int i = 0; i < 4; i++) begin m_prev[i] = light[i]; m_dwell[i] = 1; m_lamp[i] = light[i]; end
      end else begin
        m_fcyc++;
        for (int i = 0; i < 4; i++) m_lamp[i] = ((m_fcyc / BLINK_HALF) % 2 == 0) ? R : OFF;
      end
      return;
    end
    best = 1000; nonred = 0; cdir = 0;
    for (int i = 0; i < 4; i++) begin
      nd = (light[i] == m_prev[i]) ? m_dwell[i] + 1 : 1;
      if (nd > MAX_RED + 1) nd = MAX_RED + 1;
      if (!(light[i] inside {R, Y, G})) best = (8 + i < best) ? 8 + i : best;
      if (light[i] != m_prev[i] && light[i] != succ(m_prev[i])) best = (24 + i < best) ? 24 + i : best;
      if ((light[i] == G && nd > MAX_GREEN) || (light[i] == Y && nd > MAX_YELLOW))
        best = (32 + i < best) ? 32 + i : best;
      if (light[i] == R && nd > MAX_RED) best = (40 + i < best) ? 40 + i : best;
      if (m_prev[i] == Y && light[i] == R && m_dwell[i] < MIN_YELLOW) best = (48 + i < best) ? 48 + i : best;
      if (light[i] != R) begin nonred++; if (nonred == 2) cdir = i; end
      m_dwell[i] = nd;
      m_prev[i] = light[i];
    end
    if (nonred > 1 && 16 + cdir < best) best = 16 + cdir;
    if (best < 1000) begin
      m_fault = 1; m_code = best / 8; m_dir = best % 8; m_fcyc = 0;
      for (int i = 0; i < 4; i++) m_lamp[i] = R;
    end else begin
      for (int i = 0; i < 4; i++) m_lamp[i] = light[i];
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("lamps", {lamp_NORTH, lamp_EAST, lamp_WEST, lamp_SOUTH}, {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3]});
    check("fault", fault, m_fault);
    check("code", fault_code, m_code[2:0]);
    check("dir", fault_dir, m_dir[1:0]);
  endtask

  task automatic all_red();
    for (int i = 0; i < 4; i++) light[i] = R;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_clear();
    all_red(); clear_fault = 1'b1; step(); clear_fault = 1'b0;
  endtask

  int cdir, cph, crem;

  initial begin
    all_red();
    reset = 1'b0; run(2);
    check("rst_lamps", {lamp_NORTH, lamp_EAST, lamp_WEST, lamp_SOUTH}, {R, R, R, R});
    check("rst_fault", fault, 1'b0);
    reset = 1'b1;

    light[0] = G; run(20);
    check("t1_lampN_green", lamp_NORTH, G);
    light[0] = Y; run(4);
    light[0] = R; run(3);
    check("t1_no_fault", fault, 1'b0);

    light[0] = G; light[1] = G; step();
    check("t2_fault", fault, 1'b1); check("t2_code", fault_code, 3'd2); check("t2_dir", fault_dir, 2'd1);
    run(3);  check("t2_on", lamp_EAST, R);
    step();  check("t2_off", lamp_EAST, OFF);
    run(3);  check("t2_off_end", lamp_WEST, OFF);
    step();  check("t2_on_again", lamp_SOUTH, R);
    do_clear();

    light[2] = G; run(3);
    light[2] = R; step();
    check("t3_code", fault_code, 3'd3); check("t3_dir", fault_dir, 2'd2);
    do_clear();

    light[3] = G; run(64);
    check("t4_at64", fault, 1'b0);
    step();
    check("t4_code", fault_code, 3'd4); check("t4_dir", fault_dir, 2'd3);
    do_clear();
    light[3] = G; run(64); light[3] = Y; run(3); light[3] = R; run(2);
    check("t4_64_ok", fault, 1'b0);

    light[0] = 3'b111; step();
    check("t5_code", fault_code, 3'd1);
    clear_fault = 1'b1; light[0] = G; run(3);
    check("t5_stay", fault, 1'b1);
    all_red(); step(); clear_fault = 1'b0;
    check("t5_exit", fault, 1'b0); check("t5_lamps", lamp_NORTH, R);

    light[1] = G; run(2);
    light[0] = 3'b011; light[1] = R; step();
    check("t6_code", fault_code, 3'd1); check("t6_dir", fault_dir, 2'd0);
    run(3);
    reset = 1'b0; step();
    check("t6_rst_lamps", {lamp_NORTH, lamp_EAST, lamp_WEST, lamp_SOUTH}, {R, R, R, R});
    check("t6_rst_fault", fault, 1'b0); check("t6_rst_code", fault_code, 3'd0);
    reset = 1'b1; all_red();

    light[0] = G; run(3); light[0] = Y; step(); light[0] = R; step();
    check("short_yellow", fault_code, 3'd6);
    do_clear();
    run(255); check("starve_edge", fault, 1'b0);
    step();   check("starve", fault_code, 3'd5);
    do_clear();

    cph = 0; crem = 1; cdir = 0;
    for (int n = 0; n < 5000; n++) begin
      reset = ($urandom_range(0, 999) != 0);
      if (m_fault) begin
        for (int i = 0; i < 4; i++) light[i] = ($urandom_range(0, 4) == 0) ? G : R;
        if ($urandom_range(0, 1) == 0) all_red();
        clear_fault = ($urandom_range(0, 2) == 0);
        cph = 0; crem = 1;
      end else begin
        clear_fault = ($urandom_range(0, 50) == 0);
        all_red();
        if (crem == 0) begin
          case (cph)
            0:       begin cph = 1; cdir = $urandom_range(0, 3); crem = $urandom_range(1, 70); end
            1:       begin cph = 2; crem = $urandom_range(1, 18); end
            default: begin cph = 0; crem = $urandom_range(1, 4); end
          endcase
        end
        if (cph == 1) light[cdir] = G;
        else if (cph == 2) light[cdir] = Y;
        if ($urandom_range(0, 150) == 0) light[$urandom_range(0, 3)] = 3'($urandom);
        crem--;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
